// File: rtl/bch_pkg.sv
// bch_pkg: shared state encoding, default sizes and helpers for the BCH correction stage
package bch_pkg;
  localparam int DEF_CODE_LEN = 1023;
  localparam int DEF_POS_LEN = 10;
  localparam int DEF_T_CAP = 3;
  localparam int DEF_CORR_CNT_LEN = 3;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    CORRECT = 2'd3
  } state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/corr_bit_buffer.sv
// corr_bit_buffer: 1-bit wide codeword store, synchronous indexed write, asynchronous read
module corr_bit_buffer
  import bch_pkg::*;
#(
  parameter int DEPTH = DEF_CODE_LEN,
  parameter int AW = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          wdata,
  output logic          rdata
);
  logic mem [DEPTH];
  // store one hard-decision bit at the current load position
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/bch_error_corrector.sv
// bch_error_corrector: buffers a codeword then emits it XORed with the decision unit's error-location stream
module bch_error_corrector
  import bch_pkg::*;
#(
  parameter int CODE_LEN = DEF_CODE_LEN,
  parameter int POS_LEN = DEF_POS_LEN,
  parameter int T_CAP = DEF_T_CAP,
  parameter int CORR_CNT_LEN = DEF_CORR_CNT_LEN
) (
  input  logic                    clk,
  input  logic                    in_ctr_Arst_n,
  input  logic                    in_ctr_en,
  input  logic                    in_hd_valid,
  input  logic                    in_hd_bit,
  input  logic                    in_ctr_init,
  input  logic                    in_sel_tp_equal,
  output logic                    out_valid,
  output logic                    out_bit,
  output logic                    out_last,
  output logic [CORR_CNT_LEN-1:0] out_corr_cnt,
  output logic                    out_fail,
  output logic                    out_ready_load,
  output logic                    out_drop
);
  localparam logic [POS_LEN-1:0] LAST_POS = POS_LEN'(CODE_LEN - 1);
  state_t state;
  logic [POS_LEN-1:0] pos;
  logic valid_r, drop_r, rd_bit, loading, we, at_last;
  logic [CORR_CNT_LEN-1:0] cnt_next;
  assign loading = (state == IDLE) || (state == LOAD);
  assign we = in_ctr_en & in_hd_valid & loading;
  assign at_last = pos == LAST_POS;
  assign cnt_next = (in_sel_tp_equal && out_corr_cnt != '1) ? out_corr_cnt + 1'b1 : out_corr_cnt;
  assign out_ready_load = loading;
  assign out_valid = valid_r & in_ctr_en;
  assign out_drop = drop_r;
  assign out_fail = out_corr_cnt > CORR_CNT_LEN'(T_CAP);
  corr_bit_buffer #(.DEPTH(CODE_LEN), .AW(POS_LEN)) u_buf (
    .clk  (clk),
    .we   (we),
    .addr (pos),
    .wdata(in_hd_bit),
    .rdata(rd_bit)
  );
  // load/wait/correct sequencing with registered corrected-bit output; the output register holds while disabled
  always_ff @(posedge clk or negedge in_ctr_Arst_n)
    if (!in_ctr_Arst_n) begin
      state <= IDLE;
      pos <= '0;
      valid_r <= 1'b0;
      out_bit <= 1'b0;
      out_last <= 1'b0;
      out_corr_cnt <= '0;
      drop_r <= 1'b0;
    end else if (in_ctr_en) begin
      valid_r <= 1'b0;
      out_last <= 1'b0;
      drop_r <= in_hd_valid & ~loading;
      case (state)
        IDLE:
          if (in_hd_valid) begin
            pos <= POS_LEN'(1);
            state <= LOAD;
          end
        LOAD:
          if (in_hd_valid) begin
            pos <= at_last ? '0 : pos + 1'b1;
            state <= at_last ? WAIT : LOAD;
          end
        WAIT:
          if (in_ctr_init) begin
            valid_r <= 1'b1;
            out_bit <= rd_bit ^ in_sel_tp_equal;
            out_corr_cnt <= CORR_CNT_LEN'(in_sel_tp_equal);
            pos <= POS_LEN'(1);
            state <= CORRECT;
          end
        default: begin
          valid_r <= 1'b1;
          out_bit <= rd_bit ^ in_sel_tp_equal;
          out_last <= at_last;
          out_corr_cnt <= cnt_next;
          pos <= at_last ? '0 : pos + 1'b1;
          state <= at_last ? IDLE : CORRECT;
        end
      endcase
    end
endmodule
